monitor_text_reader: RTL and testbench

//   Read side of the memory-mapped text monitor. The CPU writes one ASCII character per word

---
 rtl/monitor_text_reader.sv | 140 ++++++++++++++
 tb/tb_monitor_text_reader.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_text_reader.sv
// Read side of the memory-mapped text monitor: fetches the character window through a
// 1-cycle-latency read port and streams it as a framed valid/ready byte stream.
module monitor_text_reader #(
   parameter int unsigned BASE_ADDR      = 495,
   parameter int unsigned NUM_CHARS      = 16,
   parameter int unsigned REFRESH_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rd_data,
   output logic [7:0]  char_data,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        char_first,
   output logic        char_last,
   output logic        busy,
   output logic        frame_done
);

   localparam int unsigned IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      SEND  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_next;
   logic             frame_end;
   logic             tick;

   // Blank cells read as space; anything outside printable ASCII shows as '?'.
   function automatic logic [7:0] map_char(input logic [31:0] word);
      logic [7:0] b;
      b = word[7:0];
      if (word == 32'd0) begin
         map_char = 8'h20;
      end else if ((word[31:8] != 24'd0) || (b < 8'h20) || (b > 8'h7E)) begin
         map_char = 8'h3F;
      end else begin
         map_char = b;
      end
   endfunction

   // Free-running refresh timer; tick marks the terminal count.
   generate
      if (REFRESH_CYCLES == 0) begin : g_no_refresh
         assign tick = 1'b0;
      end else begin : g_refresh
         localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
         localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_CYCLES - 1);

         logic [CNT_W-1:0] refresh_cnt;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               refresh_cnt <= '0;
            end else if (refresh_cnt == TERM) begin
               refresh_cnt <= '0;
            end else begin
               refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
         end

         assign tick = (refresh_cnt == TERM);
      end
   endgenerate

   // Next-state and character index.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      frame_end  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start || tick) begin
               state_next = FETCH;
               idx_next   = '0;
            end
         end
         FETCH: state_next = WAIT;
         WAIT:  state_next = SEND;
         SEND: begin
            if (char_valid && char_ready) begin
               if (idx == LAST_IDX) begin
                  state_next = IDLE;
                  frame_end  = 1'b1;
               end else begin
                  state_next = FETCH;
                  idx_next   = idx + IDX_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and registered outputs, decoded from the upcoming state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= 32'd0;
         char_data  <= 8'd0;
         char_valid <= 1'b0;
         char_first <= 1'b0;
         char_last  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         mem_rd_en  <= (state_next == FETCH);
         if (state_next == FETCH) begin
            mem_addr <= BASE_ADDR + 32'(idx_next);
         end
         if (state == WAIT) begin
            char_data  <= map_char(mem_rd_data);
            char_first <= (idx == '0);
            char_last  <= (idx == LAST_IDX);
         end else if (state_next != SEND) begin
            char_first <= 1'b0;
            char_last  <= 1'b0;
         end
         char_valid <= (state_next == SEND);
         busy       <= (state_next != IDLE);
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_monitor_text_reader.sv
// Bench for monitor_text_reader: timestamp-based reference model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_monitor_text_reader;

   localparam int BASE = 495;
   localparam int NCH  = 16;
   localparam int RC   = 60;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic [7:0]  char_data;
   logic        char_valid;
   logic        char_ready;
   logic        char_first;
   logic        char_last;
   logic        busy;
   logic        frame_done;

   monitor_text_reader #(
      .BASE_ADDR      (BASE),
      .NUM_CHARS      (NCH),
      .REFRESH_CYCLES (RC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .char_data   (char_data),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .char_first  (char_first),
      .char_last   (char_last),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem [NCH];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_map(input logic [31:0] w);
      if (w == 32'd0) return 8'h20;
      if (w > 32'h0000_00FF) return 8'h3F;
      if (w[7:0] < 8'h20 || w[7:0] > 8'h7E) return 8'h3F;
      return w[7:0];
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom % 5)
         0: return 32'h0;
         1: return 32'($urandom % 32);
         2: return 32'h20 + 32'($urandom % 95);
         3: return $urandom | 32'h100;
         default: return 32'h7F + 32'($urandom % 129);
      endcase
   endfunction

   task automatic load_text();
      string s;
      s = "wel comerunning.";
      for (int i = 0; i < NCH; i++) mem[i] = (i == 3) ? 32'h0 : 32'(s[i]);
   endtask

   // Memory with one cycle read latency; garbage when not being read.
   always @(posedge clk) begin
      if (mem_rd_en && mem_addr >= 32'(BASE) && mem_addr < 32'(BASE + NCH))
         mem_rd_data <= mem[4'(mem_addr - 32'(BASE))];
      else
         mem_rd_data <= $urandom;
   end

   // Reference model in edge timestamps: m_t counts edges since reset, m_ft is the
   // edge that issued the current character's read.
   int          m_t = 0;
   bit          m_act = 0;
   int          m_idx = 0;
   int          m_ft = 0;
   logic [7:0]  m_char = 0;
   bit          m_tick = 0;
   bit          e_busy = 0, e_rd = 0, e_valid = 0, e_done = 0;
   logic [31:0] e_addr = 0;

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_t = 0; m_act = 0; m_idx = 0; m_ft = 0; m_char = 0;
            e_busy = 0; e_rd = 0; e_valid = 0; e_done = 0; e_addr = 0;
         end else begin
            m_tick = (m_t % RC) == RC - 1;
            e_done = 0;
            if (m_act) begin
               if (m_t == m_ft + 1) m_char = exp_map(mem[m_idx]);
               if (m_t >= m_ft + 3 && char_ready) begin
                  if (m_idx == NCH - 1) begin
                     m_act  = 0;
                     e_done = 1;
                  end else begin
                     m_idx++;
                     m_ft = m_t;
                  end
               end
            end else if (start || m_tick) begin
               m_act = 1;
               m_idx = 0;
               m_ft  = m_t;
            end
            e_busy  = m_act;
            e_rd    = m_act && (m_ft == m_t);
            e_valid = m_act && (m_t >= m_ft + 2);
            e_addr  = 32'(BASE + m_idx);
            m_t++;
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
            chk("char_valid", 32'(char_valid), 32'(e_valid));
            chk("frame_done", 32'(frame_done), 32'(e_done));
            if (e_rd) chk("mem_addr", mem_addr, e_addr);
            if (e_valid) begin
               chk("char_data", 32'(char_data), 32'(m_char));
               chk("char_first", 32'(char_first), 32'(m_idx == 0));
               chk("char_last", 32'(char_last), 32'(m_idx == NCH - 1));
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_data"}, 32'(char_data), 0);
      chk({tag, "_valid"}, 32'(char_valid), 0);
      chk({tag, "_first"}, 32'(char_first), 0);
      chk({tag, "_last"}, 32'(char_last), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(frame_done), 0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_act && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 32'(busy), 0);
   endtask

   // Observations of one start-launched frame.
   int          sf_first_k, sf_done_k, sf_ndone, sf_nacc;
   logic [7:0]  sf_chars [NCH];
   logic [NCH-1:0] sf_firsts, sf_lasts;
   logic [31:0] sf_addr0;
   logic        sf_rd0, sf_busy_done, sf_busy_after;

   // Called at a negedge with the block idle; k counts negedges after the start edge.
   task automatic start_frame(input int stall_idx, input int stall_len,
                              input int reset_idx, input int restart_k);
      int stall_cnt;
      bit post_chk;
      bit fin;
      logic [7:0] held;
      sf_first_k = -1; sf_done_k = -1; sf_ndone = 0; sf_nacc = 0;
      sf_firsts = '0; sf_lasts = '0; sf_addr0 = '1; sf_rd0 = 0;
      sf_busy_done = 1; sf_busy_after = 1;
      stall_cnt = 0; post_chk = 0; fin = 0; held = 0;
      char_ready = 1;
      start = 1;
      for (int k = 0; k < 400 && !fin; k++) begin
         @(negedge clk);
         start = (k == restart_k);
         if (k == 0) begin
            sf_addr0 = mem_addr;
            sf_rd0   = mem_rd_en;
         end
         if (post_chk) begin
            chk("stall_next_rd", 32'(mem_rd_en), 1);
            chk("stall_next_addr", mem_addr, 32'(BASE + stall_idx + 1));
            post_chk = 0;
         end
         if (frame_done) begin
            sf_ndone++;
            if (sf_done_k < 0) begin
               sf_done_k    = k;
               sf_busy_done = busy;
            end
         end
         if (sf_done_k >= 0 && k == sf_done_k + 1) begin
            sf_busy_after = busy;
            fin = 1;
         end
         if (char_valid && sf_first_k < 0) sf_first_k = k;
         if (char_valid && sf_nacc == reset_idx) begin
            #2 reset = 1;
            #1 chk_zero("midreset");
            return;
         end
         char_ready = 1;
         if (char_valid && sf_nacc == stall_idx && stall_cnt < stall_len) begin
            if (stall_cnt == 0) held = char_data;
            else chk("stall_data", 32'(char_data), 32'(held));
            chk("stall_rd_en", 32'(mem_rd_en), 0);
            char_ready = 0;
            stall_cnt++;
         end
         if (char_valid && char_ready) begin
            if (sf_nacc < NCH) begin
               sf_chars[sf_nacc]  = char_data;
               sf_firsts[sf_nacc] = char_first;
               sf_lasts[sf_nacc]  = char_last;
            end
            if (sf_nacc == stall_idx && stall_cnt > 0) begin
               chk("stall_accept_data", 32'(char_data), 32'(held));
               post_chk = 1;
            end
            sf_nacc++;
         end
      end
      chk("frame_finished", 32'(fin), 1);
   endtask

   task automatic chk_text(input string tag);
      string s;
      s = "wel comerunning.";
      for (int i = 0; i < NCH; i++) chk(tag, 32'(sf_chars[i]), 32'(s[i]));
   endtask

   int exp_rises [6] = '{59, 119, 179, 239, 359, 479};

   initial begin
      int   vcount;
      logic prev_busy;
      int   rises [$];
      int   n;
      logic [31:0] map_in  [5];
      logic [7:0]  map_exp [5];
      map_in  = '{32'h0000_0000, 32'h0000_0007, 32'h0000_0141, 32'h0000_007F, 32'h0000_005A};
      map_exp = '{8'h20, 8'h3F, 8'h3F, 8'h3F, 8'h5A};

      reset = 1; start = 0; char_ready = 1;
      load_text();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      #2 reset = 0;

      // Auto-refresh with start tied low: full-speed, then slowed frames.
      vcount = 0; prev_busy = 0;
      for (int j = 0; j < 500; j++) begin
         @(negedge clk);
         if (busy && !prev_busy) rises.push_back(j);
         prev_busy = busy;
         if (j == 107) chk("tick_done_107", 32'(frame_done), 1);
         if (j == 319) chk("slow_done_319", 32'(frame_done), 1);
         if (j < 230) begin
            char_ready = 1;
         end else begin
            vcount = char_valid ? vcount + 1 : 0;
            char_ready = (vcount >= 3);
         end
      end
      chk("rise_count", 32'(rises.size()), 6);
      for (int i = 0; i < 6 && i < rises.size(); i++) chk("rise_cycle", 32'(rises[i]), 32'(exp_rises[i]));
      char_ready = 1;

      // Plain frame with literal timing and text.
      wait_idle();
      start_frame(-1, 0, -1, -1);
      chk("t1_rd0", 32'(sf_rd0), 1);
      chk("t1_addr0", sf_addr0, 32'(BASE));
      chk("t1_first_valid_k", 32'(sf_first_k), 2);
      chk("t1_done_k", 32'(sf_done_k), 48);
      chk("t1_ndone", 32'(sf_ndone), 1);
      chk("t1_nacc", 32'(sf_nacc), 16);
      chk("t1_firsts", 32'(sf_firsts), 32'h0001);
      chk("t1_lasts", 32'(sf_lasts), 32'h8000);
      chk_text("t1_char");

      // Backpressure on char 3 for 5 cycles.
      wait_idle();
      start_frame(3, 5, -1, -1);
      chk("t2_done_k", 32'(sf_done_k), 53);
      chk("t2_char3", 32'(sf_chars[3]), 32'h20);
      chk_text("t2_char");

      // Character mapping.
      for (int i = 0; i < 5; i++) mem[i] = map_in[i];
      wait_idle();
      start_frame(-1, 0, -1, -1);
      for (int i = 0; i < 5; i++) chk("t4_map", 32'(sf_chars[i]), 32'(map_exp[i]));
      load_text();

      // Start pulse while busy is ignored.
      wait_idle();
      start_frame(-1, 0, -1, 10);
      chk("t6_ndone", 32'(sf_ndone), 1);
      chk("t6_done_k", 32'(sf_done_k), 48);
      chk("t6_busy_at_done", 32'(sf_busy_done), 0);

      // Reset while char 7 is valid, then a clean frame.
      wait_idle();
      start_frame(-1, 0, 7, -1);
      repeat (2) @(negedge clk);
      #2 reset = 0;
      start_frame(-1, 0, -1, -1);
      chk("t5_addr0", sf_addr0, 32'(BASE));
      chk("t5_first0", 32'(sf_firsts), 32'h0001);
      chk("t5_done_k", 32'(sf_done_k), 48);
      chk_text("t5_char");

      // Start coincident with tick: exactly one frame.
      n = 0;
      while (!(m_act == 0 && (m_t % RC) == RC - 1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t6b_sync", 32'(n < 200), 1);
      start_frame(-1, 0, -1, -1);
      chk("t6b_ndone", 32'(sf_ndone), 1);
      chk("t6b_done_k", 32'(sf_done_k), 48);
      chk("t6b_busy_after", 32'(sf_busy_after), 0);

      // Randomized traffic, including memory writes during frames.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         char_ready = ($urandom % 4) != 0;
         start = ($urandom % 25) == 0;
         if (($urandom % 6) == 0) begin
            n = int'($urandom % NCH);
            mem[n] = rand_word();
         end
      end
      start = 0;
      char_ready = 1;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
